// File: rtl/ysyx_22040127_booth_mul.sv
// Iterative radix-4 Booth multiplier for the M-extension path (MUL/MULH/MULHSU/MULHU/MULW).
// Valid/ready on both sides, early exit once the remaining multiplier digits are all zero.
module ysyx_22040127_booth_mul #(
    parameter int XLEN    = 64,
    parameter bit WORD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] x,
    input  logic [XLEN-1:0] y,
    input  logic            xs,
    input  logic            ys,
    input  logic            word,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] high,
    output logic [XLEN-1:0] low
);

    localparam int PW  = 2 * XLEN;
    localparam int MRW = XLEN + 3;
    localparam int CW  = $clog2(XLEN / 2 + 1);
    localparam bit WORD_OK = WORD_EN && (XLEN >= 32);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [PW-1:0]   m_q;
    logic [MRW-1:0]  mr_q;
    logic [PW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;
    logic            word_q;
    logic [XLEN-1:0] high_q;
    logic [XLEN-1:0] low_q;

    logic            word_eff;
    logic [31:0]     x32;
    logic [31:0]     y32;
    logic [PW-1:0]   m_full;
    logic [PW-1:0]   m_word;
    logic [MRW-1:0]  mr_full;
    logic [MRW-1:0]  mr_word;

    assign word_eff = WORD_OK && word;
    assign x32      = 32'(x);
    assign y32      = 32'(y);
    assign m_full   = PW'($signed({xs & x[XLEN-1], x}));
    assign m_word   = PW'($signed({xs & x32[31], x32}));
    assign mr_full  = {{2{ys & y[XLEN-1]}}, y, 1'b0};
    assign mr_word  = MRW'($signed({{2{ys & y32[31]}}, y32, 1'b0}));

    logic [PW-1:0]   m2;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   acc_d;
    logic [PW-1:0]   m_d;
    logic [MRW-1:0]  mr_d;
    logic            uniform;
    logic [CW-1:0]   n_last;
    logic [PW-1:0]   res;
    logic [63:0]     p64;
    logic [XLEN-1:0] high_d;
    logic [XLEN-1:0] low_d;

    always_comb begin
        m2 = {m_q[PW-2:0], 1'b0};
        addend = '0;
        case (mr_q[2:0])
            3'b001, 3'b010: addend = m_q;
            3'b011:         addend = m2;
            3'b100:         addend = -m2;
            3'b101, 3'b110: addend = -m_q;
            default:        addend = '0;
        endcase
        acc_d   = acc_q + addend;
        mr_d    = {{2{mr_q[MRW-1]}}, mr_q[MRW-1:2]};
        m_d     = {m_q[PW-3:0], 2'b00};
        uniform = (mr_q == '0) || (&mr_q);
        n_last  = word_q ? CW'(16) : CW'(XLEN / 2);
        // The detect cycle latches the untouched accumulator; a capped exit latches the final add.
        res     = uniform ? acc_q : acc_d;
        p64     = 64'(res);
        if (word_q) begin
            high_d = XLEN'($signed(p64[63:32]));
            low_d  = XLEN'($signed(p64[31:0]));
        end else begin
            high_d = res[PW-1:XLEN];
            low_d  = res[XLEN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            m_q         <= '0;
            mr_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            word_q      <= 1'b0;
            high_q      <= '0;
            low_q       <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= BUSY;
                        in_ready_q <= 1'b0;
                        word_q     <= word_eff;
                        m_q        <= word_eff ? m_word : m_full;
                        mr_q       <= word_eff ? mr_word : mr_full;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                    end
                end
                BUSY: begin
                    if (uniform || (cnt_q == n_last)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        high_q      <= high_d;
                        low_q       <= low_d;
                    end
                    if (!uniform) begin
                        acc_q <= acc_d;
                        mr_q  <= mr_d;
                        m_q   <= m_d;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign high      = high_q;
    assign low       = low_q;

endmodule

// File: tb/tb_ysyx_22040127_booth_mul.sv
// Directed and randomised checks of the Booth multiplier: results, latency, handshake, flush and reset.
module tb_ysyx_22040127_booth_mul;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, xs, ys, word, out_valid, out_ready;
    logic [63:0] x, y, high, low;
    int          passed = 0;
    int          failed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    ysyx_22040127_booth_mul #(.XLEN(64), .WORD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .xs(xs), .ys(ys), .word(word),
        .out_valid(out_valid), .out_ready(out_ready), .high(high), .low(low)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [63:0] ax, ay, input logic axs, ays, aw);
        in_valid = 1'b1; x = ax; y = ay; xs = axs; ys = ays; word = aw;
        tick();
        in_valid = 1'b0;
    endtask

    // Counts edges from acceptance until out_valid is seen; call right after accept.
    task automatic wait_done(output int k);
        bit ok = 1'b0;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
            k++;
        end
        check("done_within_bound", {127'b0, ok}, 128'd1);
    endtask

    task automatic run_op(input logic [63:0] ax, ay, input logic axs, ays, aw,
                          output logic [63:0] rh, rl, output int k);
        accept(ax, ay, axs, ays, aw);
        wait_done(k);
        rh = high;
        rl = low;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    function automatic logic [127:0] model(input logic [63:0] ax, ay, input logic axs, ays, aw);
        logic [127:0] a, b;
        logic [63:0]  a64, b64, p64;
        if (!aw) begin
            a = axs ? {{64{ax[63]}}, ax} : {64'b0, ax};
            b = ays ? {{64{ay[63]}}, ay} : {64'b0, ay};
            return a * b;
        end
        a64 = axs ? {{32{ax[31]}}, ax[31:0]} : {32'b0, ax[31:0]};
        b64 = ays ? {{32{ay[31]}}, ay[31:0]} : {32'b0, ay[31:0]};
        p64 = a64 * b64;
        return {{32{p64[63]}}, p64[63:32], {32{p64[31]}}, p64[31:0]};
    endfunction

    logic [63:0]  rh, rl, rx, ry;
    logic [127:0] exp_p;
    logic         rxs, rys, rw;
    int           k;
    bit           seen;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; xs = 1'b0; ys = 1'b0; word = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("reset_in_ready", {127'b0, in_ready}, 128'd1);
        check("reset_out_valid", {127'b0, out_valid}, 128'd0);
        check("reset_high", {64'b0, high}, 128'd0);
        check("reset_low", {64'b0, low}, 128'd0);

        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, rh, rl, k);
        check("umax", {rh, rl}, {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001});

        accept(64'd5, 64'd7, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", {127'b0, in_ready}, 128'd1);
        check("midrst_out_valid", {127'b0, out_valid}, 128'd0);
        check("midrst_result", {high, low}, 128'd0);

        run_op(-64'sd3, 64'd7, 1'b1, 1'b1, 1'b0, rh, rl, k);
        check("signed_small", {rh, rl}, {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB});

        run_op(64'h1234, 64'd0, 1'b0, 1'b0, 1'b0, rh, rl, k);
        check("y0_result", {rh, rl}, 128'd0);
        check("y0_k", k, 128'd1);

        run_op(64'hDEAD, 64'd1, 1'b0, 1'b0, 1'b0, rh, rl, k);
        check("y1_result", {rh, rl}, 128'hDEAD);
        check("y1_k", k, 128'd2);

        run_op(64'd3, 64'h5555_5555_5555_5555, 1'b0, 1'b0, 1'b0, rh, rl, k);
        check("full_result", {rh, rl}, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF});
        check("full_k", k, 128'd33);

        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 1'b0, 1'b0, rh, rl, k);
        check("mulhsu", {rh, rl}, {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE});

        run_op(64'h0000_0000_8000_0000, 64'd2, 1'b1, 1'b1, 1'b1, rh, rl, k);
        check("word_neg", {rh, rl}, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});

        run_op(64'h7FFF_FFFF, 64'd2, 1'b1, 1'b1, 1'b1, rh, rl, k);
        check("word_wrap", {rh, rl}, {64'h0, 64'hFFFF_FFFF_FFFF_FFFE});

        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_5555_5555, 1'b0, 1'b0, 1'b1, rh, rl, k);
        check("word_k_cap", k, 128'd17);

        accept(64'd6, 64'd7, 1'b0, 1'b0, 1'b0);
        wait_done(k);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {127'b0, out_valid}, 128'd1);
            check("hold_result", {high, low}, 128'd42);
            check("hold_in_ready", {127'b0, in_ready}, 128'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("consumed_valid", {127'b0, out_valid}, 128'd0);
        check("consumed_in_ready", {127'b0, in_ready}, 128'd1);

        flush = 1'b1;
        accept(64'd9, 64'd9, 1'b0, 1'b0, 1'b0);
        flush = 1'b0;
        check("flush_idle_not_accepted", {127'b0, in_ready}, 128'd1);
        tick(); tick();
        check("flush_idle_no_valid", {127'b0, out_valid}, 128'd0);

        accept(64'd3, 64'h5555_5555_5555_5555, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy_in_ready", {127'b0, in_ready}, 128'd1);
        check("flush_busy_out_valid", {127'b0, out_valid}, 128'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen |= out_valid;
            tick();
        end
        check("flush_busy_never_valid", {127'b0, seen}, 128'd0);
        check("flush_busy_result_kept", {high, low}, 128'd42);

        accept(64'd2, 64'd3, 1'b0, 1'b0, 1'b0);
        wait_done(k);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0;
        check("flush_done_valid", {127'b0, out_valid}, 128'd0);
        check("flush_done_in_ready", {127'b0, in_ready}, 128'd1);
        check("flush_done_result", {high, low}, 128'd6);

        out_ready = 1'b1;
        accept(64'd4, 64'd5, 1'b0, 1'b0, 1'b0);
        wait_done(k);
        check("ready_high_result", {high, low}, 128'd20);
        tick();
        check("ready_high_consumed", {127'b0, out_valid}, 128'd0);
        check("ready_high_in_ready", {127'b0, in_ready}, 128'd1);
        out_ready = 1'b0;

        for (int i = 0; i < 300; i++) begin
            rx  = {$urandom, $urandom};
            ry  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) ry = 64'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) ry = ~ry;
            rxs = 1'($urandom_range(0, 1));
            rys = 1'($urandom_range(0, 1));
            rw  = 1'($urandom_range(0, 1));
            exp_p = model(rx, ry, rxs, rys, rw);
            run_op(rx, ry, rxs, rys, rw, rh, rl, k);
            check("rand_result", {rh, rl}, exp_p);
            check("rand_k_range", {127'b0, (k >= 1) && (k <= (rw ? 17 : 33))}, 128'd1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
